// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issue stage for the 8-bit ALU. Takes opcode/operand commands
//                over valid/ready, registers them onto the ALU inputs, and
//                captures the ALU result one cycle later. Results leave over
//                a valid/ready port. The last result is kept in an
//                accumulator so commands can chain, and completed handoffs
//                are counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int         CNT_W    = 16,
    parameter logic [7:0] ACC_INIT = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_chain,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_illegal,
    output logic [7:0]       acc,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0]       C_MAX_LEGAL_OP = 4'hC;
    localparam logic [CNT_W-1:0] C_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_handoff;
    logic             r_illegal;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [3:0]       r_alu_sel;
    logic             r_res_valid;
    logic [7:0]       r_res_data;
    logic             r_res_carry;
    logic             r_res_zero;
    logic             r_res_illegal;
    logic [7:0]       r_acc;
    logic [CNT_W-1:0] r_ops_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus handshake decode; res_ready reaches cmd_ready combinationally
    // so a new command can enter in the same cycle the previous result leaves.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        w_handoff    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = !rst;
            end
            S_HOLD: begin
                cmd_ready = !rst && res_ready;
                w_handoff = res_ready;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
        w_accept = cmd_valid && cmd_ready;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_DRIVE;
            S_DRIVE: w_state_next = S_HOLD;
            S_HOLD: begin
                if (res_ready) begin
                    w_state_next = cmd_valid ? S_DRIVE : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch command on accept, capture ALU result out of DRIVE,
    // retire the result and count it on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a       <= 8'h00;
            r_alu_b       <= 8'h00;
            r_alu_sel     <= 4'h0;
            r_illegal     <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= 8'h00;
            r_res_carry   <= 1'b0;
            r_res_zero    <= 1'b0;
            r_res_illegal <= 1'b0;
            r_acc         <= ACC_INIT;
            r_ops_done    <= '0;
        end else begin
            if (w_accept) begin
                // In the HOLD->DRIVE overlap r_acc already holds the result being handed off.
                r_alu_a   <= cmd_chain ? r_acc : cmd_a;
                r_alu_b   <= cmd_b;
                r_alu_sel <= cmd_op;
                r_illegal <= (cmd_op > C_MAX_LEGAL_OP);
            end
            if (r_state == S_DRIVE) begin
                r_res_valid   <= 1'b1;
                r_res_data    <= alu_out;
                r_res_carry   <= alu_carry;
                r_res_zero    <= alu_zero;
                r_res_illegal <= r_illegal;
                r_acc         <= alu_out;
            end else if (w_handoff) begin
                r_res_valid <= 1'b0;
                r_ops_done  <= r_ops_done + C_CNT_ONE;
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_sel     = r_alu_sel;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_carry   = r_res_carry;
    assign res_zero    = r_res_zero;
    assign res_illegal = r_res_illegal;
    assign acc         = r_acc;
    assign ops_done    = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer with a
//                small behavioural ALU closing the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int         CNT_W    = 2;
    localparam logic [7:0] ACC_INIT = 8'h5A;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic             cmd_chain;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [3:0]       alu_sel;
    logic [7:0]       alu_out;
    logic             alu_carry;
    logic             alu_zero;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic             res_carry;
    logic             res_zero;
    logic             res_illegal;
    logic [7:0]       acc;
    logic [CNT_W-1:0] ops_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .CNT_W    (CNT_W),
        .ACC_INIT (ACC_INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_chain   (cmd_chain),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .res_zero    (res_zero),
        .res_illegal (res_illegal),
        .acc         (acc),
        .ops_done    (ops_done)
    );

    // Behavioural ALU: carry only from op 2, illegal opcodes yield 0.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum   = 9'h000;
        alu_carry = 1'b0;
        case (alu_sel)
            4'h0: alu_out = alu_a + alu_b;
            4'h1: alu_out = alu_a - alu_b;
            4'h2: begin
                alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out   = alu_sum[7:0];
                alu_carry = alu_sum[8];
            end
            4'h3: alu_out = alu_a & alu_b;
            4'h4: alu_out = alu_a | alu_b;
            4'h5: alu_out = alu_a ^ alu_b;
            4'h6: alu_out = ~alu_a;
            4'h7: alu_out = {alu_a[6:0], 1'b0};
            4'h8: alu_out = {1'b0, alu_a[7:1]};
            4'h9: alu_out = alu_a + 8'h01;
            4'hA: alu_out = alu_a - 8'h01;
            4'hB: alu_out = alu_b;
            4'hC: alu_out = alu_a;
            default: alu_out = 8'h00;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic chain);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 4'h0;
        cmd_a     = 8'h11;
        cmd_b     = 8'h22;
        cmd_chain = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_checks++; if (acc !== 8'h5A) begin n_fail++; $display("FAIL reset_acc: got %h want 5a", acc); end
        n_checks++; if (ops_done !== 2'd0) begin n_fail++; $display("FAIL reset_ops_done: got %0d want 0", ops_done); end
        n_checks++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin n_fail++; $display("FAIL reset_alu_regs: got %h want 0", {alu_a, alu_b, alu_sel}); end
        n_checks++; if (res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res_data: got %h want 00", res_data); end
        cmd_valid = 1'b0;
        rst       = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_basic_add();
        res_ready = 1'b1;
        drive_cmd(4'h0, 8'h0F, 8'h01, 1'b0);
        tick();   // accept edge
        cmd_valid = 1'b0;
        n_checks++; if ({alu_a, alu_b, alu_sel} !== {8'h0F, 8'h01, 4'h0}) begin n_fail++; $display("FAIL add_alu_regs: got %h want 0f010", {alu_a, alu_b, alu_sel}); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: got %b want 0", res_valid); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL add_ready_drive: got %b want 0", cmd_ready); end
        tick();   // capture edge
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL add_res_valid: got %b want 1", res_valid); end
        n_checks++; if ({res_data, res_carry, res_zero, res_illegal} !== {8'h10, 3'b000}) begin n_fail++; $display("FAIL add_result: got %h/%b%b%b want 10/000", res_data, res_carry, res_zero, res_illegal); end
        n_checks++; if (acc !== 8'h10) begin n_fail++; $display("FAIL add_acc: got %h want 10", acc); end
        tick();   // handoff edge
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_handoff_valid: got %b want 0", res_valid); end
        n_checks++; if (ops_done !== 2'd1) begin n_fail++; $display("FAIL add_ops_done: got %0d want 1", ops_done); end
    endtask

    task automatic test_carry();
        res_ready = 1'b1;
        drive_cmd(4'h2, 8'hFF, 8'h01, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        n_checks++; if ({res_data, res_carry, res_zero} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL carry_result: got %h/%b%b want 00/11", res_data, res_carry, res_zero); end
        n_checks++; if (acc !== 8'h00) begin n_fail++; $display("FAIL carry_acc: got %h want 00", acc); end
        tick();
        n_checks++; if (ops_done !== 2'd2) begin n_fail++; $display("FAIL carry_ops_done: got %0d want 2", ops_done); end
    endtask

    task automatic test_chain();
        do_reset();
        res_ready = 1'b1;
        drive_cmd(4'h0, 8'h05, 8'h03, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();   // now HOLD with 08
        n_checks++; if (res_data !== 8'h08) begin n_fail++; $display("FAIL chain_first: got %h want 08", res_data); end
        drive_cmd(4'h7, 8'hAA, 8'h00, 1'b1);
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL chain_overlap_ready: got %b want 1", cmd_ready); end
        tick();   // handoff + accept
        cmd_valid = 1'b0;
        n_checks++; if (alu_a !== 8'h08) begin n_fail++; $display("FAIL chain_alu_a: got %h want 08", alu_a); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL chain_overlap_valid: got %b want 0", res_valid); end
        tick();
        n_checks++; if ({res_valid, res_data, acc} !== {1'b1, 8'h10, 8'h10}) begin n_fail++; $display("FAIL chain_result: got %b/%h/%h want 1/10/10", res_valid, res_data, acc); end
        tick();
        n_checks++; if (ops_done !== 2'd2) begin n_fail++; $display("FAIL chain_ops_done: got %0d want 2", ops_done); end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        drive_cmd(4'h1, 8'h20, 8'h05, 1'b0);
        tick();
        res_ready = 1'b0;
        drive_cmd(4'h4, 8'h0F, 8'hF0, 1'b0);
        tick();   // HOLD with 1B, consumer stalled
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if ({res_valid, res_data} !== {1'b1, 8'h1B}) begin n_fail++; $display("FAIL stall_hold_%0d: got %b/%h want 1/1b", i, res_valid, res_data); end
            n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_%0d: got %b want 0", i, cmd_ready); end
            n_checks++; if (alu_a !== 8'h20) begin n_fail++; $display("FAIL stall_alu_a_%0d: got %h want 20", i, alu_a); end
        end
        res_ready = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
        tick();   // handoff + accept
        cmd_valid = 1'b0;
        n_checks++; if ({alu_a, alu_b, alu_sel} !== {8'h0F, 8'hF0, 4'h4}) begin n_fail++; $display("FAIL b2b_alu_regs: got %h want 0ff04", {alu_a, alu_b, alu_sel}); end
        n_checks++; if (ops_done !== 2'd3) begin n_fail++; $display("FAIL b2b_ops_first: got %0d want 3", ops_done); end
        tick();
        n_checks++; if ({res_valid, res_data} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL b2b_second: got %b/%h want 1/ff", res_valid, res_data); end
        tick();
        n_checks++; if (ops_done !== 2'd0) begin n_fail++; $display("FAIL b2b_ops_wrap: got %0d want 0", ops_done); end
    endtask

    task automatic test_illegal();
        res_ready = 1'b1;
        drive_cmd(4'hF, 8'h12, 8'h34, 1'b0);
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (alu_sel !== 4'hF) begin n_fail++; $display("FAIL illegal_alu_sel: got %h want f", alu_sel); end
        tick();
        n_checks++; if ({res_data, res_zero, res_illegal, res_carry} !== {8'h00, 3'b110}) begin n_fail++; $display("FAIL illegal_result: got %h/%b%b%b want 00/110", res_data, res_zero, res_illegal, res_carry); end
        tick();
        n_checks++; if (ops_done !== 2'd1) begin n_fail++; $display("FAIL illegal_ops_done: got %0d want 1", ops_done); end
        drive_cmd(4'hC, 8'h77, 8'h00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        n_checks++; if ({res_data, res_illegal} !== {8'h77, 1'b0}) begin n_fail++; $display("FAIL legal_after_illegal: got %h/%b want 77/0", res_data, res_illegal); end
        tick();
    endtask

    task automatic test_reset_in_drive();
        res_ready = 1'b1;
        drive_cmd(4'h0, 8'h01, 8'h01, 1'b0);
        tick();   // DRIVE
        cmd_valid = 1'b0;
        rst       = 1'b1;
        tick();
        n_checks++; if ({res_valid, acc, ops_done} !== {1'b0, 8'h5A, 2'd0}) begin n_fail++; $display("FAIL rst_drive_state: got %b/%h/%0d want 0/5a/0", res_valid, acc, ops_done); end
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if ({res_valid, acc} !== {1'b0, 8'h5A}) begin n_fail++; $display("FAIL rst_drive_no_result: got %b/%h want 0/5a", res_valid, acc); end
        for (int i = 0; i < 4; i++) begin
            drive_cmd(4'h9, 8'h00, 8'h00, 1'b1);
            tick();
            cmd_valid = 1'b0;
            tick();
            tick();
            n_checks++; if (ops_done !== 2'((i + 1) % 4)) begin n_fail++; $display("FAIL wrap_ops_%0d: got %0d want %0d", i, ops_done, (i + 1) % 4); end
        end
        n_checks++; if (acc !== 8'h5E) begin n_fail++; $display("FAIL wrap_chain_acc: got %h want 5e", acc); end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_chain = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_carry();
        test_chain();
        test_back_to_back();
        test_illegal();
        test_reset_in_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
